timebase_pulse_gen: RTL and testbench

Free-running timebase that divides OPB_CLK into single-cycle strobes at 1 µs, 100 µs, 1 ms and 1 s, plus a 32-bit count of elapsed 100 µs periods. It sits directly upstream of the FPGA watchdog-kick logic and the other periodic housekeeping blocks, and drives their PULSE_100US input. The divider is loadable at runtime, so the same netlist serves boards with different OPB_CLK frequencies.

---
 rtl/timebase_pulse_gen_if.sv | 24 ++
 rtl/timebase_pulse_gen.sv | 104 ++++++++++
 tb/tb_timebase_pulse_gen.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/timebase_pulse_gen_if.sv
// Control and strobe bundle of the timebase: enable/realign/divider-load requests in,
// 1 us / 100 us / 1 ms / 1 s strobes and the 100 us tick count out.
interface timebase_pulse_gen_if;
  logic        enable;
  logic        sync_clr;
  logic        load;
  logic [15:0] div_in;
  logic        load_err;
  logic        pulse_1us;
  logic        pulse_100us;
  logic        pulse_1ms;
  logic        pulse_1s;
  logic [31:0] tick_count_100us;

  modport master (
    output enable, sync_clr, load, div_in,
    input  load_err, pulse_1us, pulse_100us, pulse_1ms, pulse_1s, tick_count_100us
  );

  modport slave (
    input  enable, sync_clr, load, div_in,
    output load_err, pulse_1us, pulse_100us, pulse_1ms, pulse_1s, tick_count_100us
  );
endinterface

// File: rtl/timebase_pulse_gen.sv
// Free-running timebase: loadable prescaler to 1 us, then a 100/10/1000 cascade
// producing 100 us, 1 ms and 1 s strobes plus a wrapping count of 100 us periods.
module timebase_pulse_gen #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic                 i_opb_clk,
  input  logic                 i_opb_rst,
  timebase_pulse_gen_if.slave  bus
);

  localparam logic [15:0] DIV_DEFAULT = 16'(CLK_FREQ_HZ / 1_000_000);

  logic [15:0] r_div_reg;
  logic [15:0] r_pre_cnt;
  logic [6:0]  r_us_cnt;
  logic [3:0]  r_hus_cnt;
  logic [9:0]  r_ms_cnt;
  logic [31:0] r_tick;
  logic        r_load_err;
  logic        r_pulse_1us;
  logic        r_pulse_100us;
  logic        r_pulse_1ms;
  logic        r_pulse_1s;

  logic w_pre_tc;
  logic w_us_tc;
  logic w_hus_tc;
  logic w_ms_tc;

  assign w_pre_tc = (r_pre_cnt == (r_div_reg - 16'd1));
  assign w_us_tc  = (r_us_cnt == 7'd99);
  assign w_hus_tc = (r_hus_cnt == 4'd9);
  assign w_ms_tc  = (r_ms_cnt == 10'd999);

  always_ff @(posedge i_opb_clk) begin
    if (i_opb_rst) begin
      r_div_reg     <= DIV_DEFAULT;
      r_pre_cnt     <= '0;
      r_us_cnt      <= '0;
      r_hus_cnt     <= '0;
      r_ms_cnt      <= '0;
      r_tick        <= '0;
      r_load_err    <= 1'b0;
      r_pulse_1us   <= 1'b0;
      r_pulse_100us <= 1'b0;
      r_pulse_1ms   <= 1'b0;
      r_pulse_1s    <= 1'b0;
    end else begin
      // Strobes are single-cycle: only the terminal-count branch below raises them.
      r_load_err    <= 1'b0;
      r_pulse_1us   <= 1'b0;
      r_pulse_100us <= 1'b0;
      r_pulse_1ms   <= 1'b0;
      r_pulse_1s    <= 1'b0;
      if (bus.sync_clr) begin
        r_pre_cnt <= '0;
        r_us_cnt  <= '0;
        r_hus_cnt <= '0;
        r_ms_cnt  <= '0;
      end else if (bus.load) begin
        if (bus.div_in >= 16'd2) begin
          r_div_reg <= bus.div_in;
          r_pre_cnt <= '0;
        end else begin
          r_load_err <= 1'b1;
        end
      end else if (bus.enable) begin
        if (w_pre_tc) begin
          r_pre_cnt   <= '0;
          r_pulse_1us <= 1'b1;
          if (w_us_tc) begin
            r_us_cnt      <= '0;
            r_pulse_100us <= 1'b1;
            r_tick        <= r_tick + 32'd1;
            if (w_hus_tc) begin
              r_hus_cnt   <= '0;
              r_pulse_1ms <= 1'b1;
              if (w_ms_tc) begin
                r_ms_cnt   <= '0;
                r_pulse_1s <= 1'b1;
              end else begin
                r_ms_cnt <= r_ms_cnt + 10'd1;
              end
            end else begin
              r_hus_cnt <= r_hus_cnt + 4'd1;
            end
          end else begin
            r_us_cnt <= r_us_cnt + 7'd1;
          end
        end else begin
          r_pre_cnt <= r_pre_cnt + 16'd1;
        end
      end
    end
  end

  assign bus.load_err         = r_load_err;
  assign bus.pulse_1us        = r_pulse_1us;
  assign bus.pulse_100us      = r_pulse_100us;
  assign bus.pulse_1ms        = r_pulse_1ms;
  assign bus.pulse_1s         = r_pulse_1s;
  assign bus.tick_count_100us = r_tick;

endmodule

// File: tb/tb_timebase_pulse_gen.sv
// Directed bench for timebase_pulse_gen at CLK_FREQ_HZ = 4 MHz (divider 4).
module tb_timebase_pulse_gen;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  timebase_pulse_gen_if bus();

  timebase_pulse_gen #(.CLK_FREQ_HZ(4_000_000)) dut (
    .i_opb_clk (clk),
    .i_opb_rst (rst),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and return on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [3:0] strobes();
    return {bus.pulse_1us, bus.pulse_100us, bus.pulse_1ms, bus.pulse_1s};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.enable = 1'b0; bus.sync_clr = 1'b0; bus.load = 1'b0; bus.div_in = 16'd0;
    repeat (3) step();
    vectors++;
    if (strobes() !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_strobes got %b expected 0000", strobes());
    end
    vectors++;
    if (bus.load_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_load_err got %b expected 0", bus.load_err);
    end
    vectors++;
    if (bus.tick_count_100us !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_tick got %h expected 0", bus.tick_count_100us);
    end
    rst = 1'b0;
    bus.enable = 1'b1;
  endtask

  // Cycles 1..4000 from reset release: 1us every 4, 100us every 400, 1ms at 4000.
  task automatic test_basic();
    logic [3:0] exp;
    for (int k = 1; k <= 4000; k++) begin
      step();
      exp = {(k % 4) == 0, (k % 400) == 0, (k % 4000) == 0, 1'b0};
      vectors++;
      if (strobes() !== exp) begin
        miscompares++;
        $display("FAIL basic_strobes cycle %0d got %b expected %b", k, strobes(), exp);
      end
      vectors++;
      if (bus.tick_count_100us !== 32'(k / 400)) begin
        miscompares++;
        $display("FAIL basic_tick cycle %0d got %0d expected %0d", k, bus.tick_count_100us, k / 400);
      end
    end
  endtask

  // Counters placed one 1us period before the 1 s boundary.
  task automatic test_one_second();
    logic [3:0] exp;
    force dut.r_us_cnt  = 7'd99;
    force dut.r_hus_cnt = 4'd9;
    force dut.r_ms_cnt  = 10'd999;
    #1;
    release dut.r_us_cnt;
    release dut.r_hus_cnt;
    release dut.r_ms_cnt;
    for (int k = 1; k <= 4; k++) begin
      step();
      exp = (k == 4) ? 4'b1111 : 4'b0000;
      vectors++;
      if (strobes() !== exp) begin
        miscompares++;
        $display("FAIL one_second_strobes cycle %0d got %b expected %b", k, strobes(), exp);
      end
    end
    vectors++;
    if (bus.tick_count_100us !== 32'd11) begin
      miscompares++;
      $display("FAIL one_second_tick got %0d expected 11", bus.tick_count_100us);
    end
    // All cascade stages restart at 0: next 100us after 400 cycles, with no 1ms.
    for (int k = 1; k <= 400; k++) begin
      step();
      exp = {(k % 4) == 0, k == 400, 1'b0, 1'b0};
      vectors++;
      if (strobes() !== exp) begin
        miscompares++;
        $display("FAIL after_second_strobes cycle %0d got %b expected %b", k, strobes(), exp);
      end
    end
    vectors++;
    if (bus.tick_count_100us !== 32'd12) begin
      miscompares++;
      $display("FAIL after_second_tick got %0d expected 12", bus.tick_count_100us);
    end
  endtask

  task automatic test_load();
    logic exp_p;
    logic exp_e;
    // Bad load at pre_cnt=1: error strobe, pre_cnt held, period stays 4.
    step();
    bus.load = 1'b1; bus.div_in = 16'd1;
    for (int k = 0; k <= 12; k++) begin
      step();
      bus.load = 1'b0;
      exp_e = (k == 0);
      exp_p = (k > 0) && ((k % 4) == 3);
      vectors++;
      if ({bus.load_err, bus.pulse_1us} !== {exp_e, exp_p}) begin
        miscompares++;
        $display("FAIL bad_load cycle %0d got err=%b p1us=%b expected err=%b p1us=%b",
                 k, bus.load_err, bus.pulse_1us, exp_e, exp_p);
      end
    end
    // Good load of 10 mid-period.
    bus.load = 1'b1; bus.div_in = 16'd10;
    for (int k = 0; k <= 30; k++) begin
      step();
      bus.load = 1'b0;
      exp_p = (k > 0) && ((k % 10) == 0);
      vectors++;
      if ({bus.load_err, bus.pulse_1us} !== {1'b0, exp_p}) begin
        miscompares++;
        $display("FAIL load_10 cycle %0d got err=%b p1us=%b expected err=0 p1us=%b",
                 k, bus.load_err, bus.pulse_1us, exp_p);
      end
    end
    // Load of 4 exactly at terminal count: that strobe is suppressed.
    repeat (9) step();
    bus.load = 1'b1; bus.div_in = 16'd4;
    for (int k = 0; k <= 8; k++) begin
      step();
      bus.load = 1'b0;
      exp_p = (k > 0) && ((k % 4) == 0);
      vectors++;
      if (bus.pulse_1us !== exp_p) begin
        miscompares++;
        $display("FAIL load_at_tc cycle %0d got p1us=%b expected %b", k, bus.pulse_1us, exp_p);
      end
    end
  endtask

  // us_cnt is 8 here; 42 more 1us periods reach us_cnt=50, then 2 cycles for pre_cnt=2.
  task automatic test_enable_hold();
    logic [3:0] exp;
    repeat (42 * 4 + 2) step();
    bus.enable = 1'b0;
    for (int k = 1; k <= 37; k++) begin
      step();
      vectors++;
      if (strobes() !== 4'b0000) begin
        miscompares++;
        $display("FAIL enable_low cycle %0d got %b expected 0000", k, strobes());
      end
    end
    bus.enable = 1'b1;
    for (int k = 1; k <= 198; k++) begin
      step();
      exp = {(k % 4) == 2, k == 198, 1'b0, 1'b0};
      vectors++;
      if (strobes() !== exp) begin
        miscompares++;
        $display("FAIL enable_resume cycle %0d got %b expected %b", k, strobes(), exp);
      end
    end
    vectors++;
    if (bus.tick_count_100us !== 32'd13) begin
      miscompares++;
      $display("FAIL enable_resume_tick got %0d expected 13", bus.tick_count_100us);
    end
  endtask

  task automatic test_tick_wrap();
    force dut.r_tick    = 32'hFFFF_FFFF;
    force dut.r_us_cnt  = 7'd99;
    force dut.r_pre_cnt = 16'd3;
    #1;
    release dut.r_tick;
    release dut.r_us_cnt;
    release dut.r_pre_cnt;
    step();
    vectors++;
    if ({bus.pulse_1us, bus.pulse_100us} !== 2'b11) begin
      miscompares++;
      $display("FAIL wrap_strobes got %b expected 11", {bus.pulse_1us, bus.pulse_100us});
    end
    vectors++;
    if (bus.tick_count_100us !== 32'd0) begin
      miscompares++;
      $display("FAIL wrap_tick got %h expected 00000000", bus.tick_count_100us);
    end
  endtask

  // Reach us_cnt=99, pre_cnt=3, then SYNC_CLR+LOAD(8) on the edge that would fire 100us.
  task automatic test_sync_clr();
    logic [3:0] exp;
    repeat (99 * 4 + 3) step();
    bus.sync_clr = 1'b1; bus.load = 1'b1; bus.div_in = 16'd8;
    step();
    bus.sync_clr = 1'b0; bus.load = 1'b0;
    vectors++;
    if ({strobes(), bus.load_err} !== 5'b00000) begin
      miscompares++;
      $display("FAIL sync_clr_edge got %b expected 00000", {strobes(), bus.load_err});
    end
    for (int k = 1; k <= 400; k++) begin
      step();
      exp = {(k % 4) == 0, k == 400, 1'b0, 1'b0};
      vectors++;
      if (strobes() !== exp) begin
        miscompares++;
        $display("FAIL sync_clr_after cycle %0d got %b expected %b", k, strobes(), exp);
      end
    end
    vectors++;
    if (bus.tick_count_100us !== 32'd1) begin
      miscompares++;
      $display("FAIL sync_clr_tick got %0d expected 1", bus.tick_count_100us);
    end
  endtask

  // Reset mid-count restores divider 4 and clears tick.
  task automatic test_reset_mid();
    logic exp_p;
    bus.load = 1'b1; bus.div_in = 16'd6;
    step();
    bus.load = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    vectors++;
    if ({strobes(), bus.load_err} !== 5'b00000 || bus.tick_count_100us !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mid got strobes=%b tick=%0d expected 0000 0",
               strobes(), bus.tick_count_100us);
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_p = (k % 4) == 0;
      vectors++;
      if (bus.pulse_1us !== exp_p) begin
        miscompares++;
        $display("FAIL reset_mid_period cycle %0d got %b expected %b", k, bus.pulse_1us, exp_p);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    test_reset();
    test_basic();
    test_one_second();
    test_load();
    test_enable_hold();
    test_tick_wrap();
    test_sync_clr();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
